mem_req_scheduler: RTL

Upstream command stage for the 16x32 single-port memory. It accepts read/write requests on a valid/ready interface and buffers them in a small in-order FIFO. It drives the memory's wenable/renable/addr/data_in pins one command at a time, captures read data and returns it on a backpressured response channel. This is the only master of the memory in the subsystem.

---
 rtl/mem_req_scheduler_if.sv | 30 +++
 rtl/mem_req_scheduler.sv | 83 ++++++++
 2 files changed

// File: rtl/mem_req_scheduler_if.sv
// mem_req_scheduler_if: request, response and memory-pin bundle around the scheduler.
interface mem_req_scheduler_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              mem_wenable;
  logic              mem_renable;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata, mem_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy, mem_wenable, mem_renable, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata, mem_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy, mem_wenable, mem_renable, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: in-order request FIFO feeding the single-port memory one command
// at a time, with captured read data returned on a backpressured response channel.
module mem_req_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32
) (
  input logic                clk,
  input logic                rst,
  mem_req_scheduler_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, WR, RD, CAP, RSP} state_t;
  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } cmd_t;
  state_t            state_q, state_d;
  cmd_t              fifo_q [FIFO_DEPTH];
  cmd_t              cmd_q, cmd_d, head, req;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              rdy_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              full, push, pop;

  always_comb begin
    full     = count_q == (PW+1)'(FIFO_DEPTH);
    push     = bus.req_valid && rdy_q && !full;
    head     = fifo_q[rd_ptr_q];
    req      = {bus.req_write, bus.req_addr, bus.req_wdata};
    // a pending response must be consumed before the next command may issue
    pop      = count_q != '0 && (state_q == IDLE || state_q == WR || (state_q == RSP && bus.rsp_ready));
    state_d  = pop ? (head.w ? WR : RD) :
               state_q == RD ? CAP :
               state_q == CAP ? RSP :
               (state_q == RSP && !bus.rsp_ready) ? RSP : IDLE;
    cmd_d    = pop ? head : cmd_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    rdata_d  = state_q == CAP ? bus.mem_rdata : rdata_q;
    err_d    = state_q == CAP ? !bus.mem_valid : err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= 1'b1;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= req;
  end

  assign bus.req_ready   = rdy_q && !full;
  assign bus.rsp_valid   = state_q == RSP;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.busy        = state_q != IDLE || count_q != '0;
  assign bus.mem_wenable = state_q == WR;
  assign bus.mem_renable = state_q == RD;
  assign bus.mem_addr    = cmd_q.a;
  assign bus.mem_wdata   = cmd_q.d;
endmodule
